// File: rtl/dmem_bus_responder.sv
// Target-side data-bus responder: byte-enabled word RAM plus CYCLE and TOHOST
// registers, one outstanding transaction with a fixed number of wait states.
module dmem_bus_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] tohost,
  output logic        tohost_valid,
  output logic [1:0]  dbg_state
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Handshake: a request is taken when req_valid && req_ready at a rising
  // edge; a response is retired when rsp_valid && rsp_ready at a rising edge.
  state_t      state_q, state_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] tohost_q, tohost_d;
  logic        tohost_valid_q, tohost_valid_d;
  logic [31:0] cycle_q, cycle_d;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] ram_word;
  logic [31:0] be_mask;
  logic [AW-1:0] word_idx;
  logic        accept, aligned, hit_ram, hit_cycle, hit_tohost, fault, ram_we;

  assign req_ready    = (state_q == ST_IDLE);
  assign accept       = req_valid && req_ready && !rst;
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign tohost       = tohost_q;
  assign tohost_valid = tohost_valid_q;
  assign dbg_state    = state_q;

  assign word_idx   = req_addr[AW+1:2];
  assign ram_word   = mem_q[word_idx];
  assign be_mask    = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
  assign aligned    = (req_addr[1:0] == 2'b00);
  assign hit_ram    = (req_addr < RAM_BYTES);
  assign hit_cycle  = (req_addr == MMIO_BASE);
  assign hit_tohost = (req_addr == MMIO_BASE + 32'h4);
  assign fault      = !(aligned && (hit_ram || hit_cycle || hit_tohost));

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    tohost_d       = tohost_q;
    tohost_valid_d = 1'b0;
    cycle_d        = cycle_q + 32'd1;
    ram_we         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d   = fault;
          rdata_d = 32'h0;
          if (!fault && !req_we) begin
            if (hit_ram)        rdata_d = ram_word;
            else if (hit_cycle) rdata_d = cycle_q;
            else                rdata_d = tohost_q;
          end
          if (!fault && req_we) begin
            ram_we = hit_ram;
            if (hit_tohost) begin
              tohost_d       = (tohost_q & ~be_mask) | (req_wdata & be_mask);
              tohost_valid_d = 1'b1;
            end
          end
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = 3'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q <= 3'd1) state_d = ST_RESP;
        else                    wait_cnt_d = wait_cnt_q - 3'd1;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      wait_cnt_q     <= 3'd0;
      rdata_q        <= 32'h0;
      err_q          <= 1'b0;
      tohost_q       <= 32'h0;
      tohost_valid_q <= 1'b0;
      cycle_q        <= 32'h0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      rdata_q        <= rdata_d;
      err_q          <= err_d;
      tohost_q       <= tohost_d;
      tohost_valid_q <= tohost_valid_d;
      cycle_q        <= cycle_d;
    end
  end

  // RAM is deliberately not reset; only enabled byte lanes are written.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) mem_q[word_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Bench for dmem_bus_responder: a reference model predicts {err, rdata} at
// drive time into a queue; each response pops and compares against it.
module tb_dmem_bus_responder;

  localparam int          DEPTH = 256;
  localparam int          WS    = 1;
  localparam logic [31:0] MMIO  = 32'h1000_0000;
  localparam int          AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_err, tohost_valid;
  logic [31:0] rsp_rdata, tohost;
  logic [1:0]  dbg_state;

  dmem_bus_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .MMIO_BASE(MMIO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .tohost(tohost), .tohost_valid(tohost_valid),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  logic [31:0] tb_cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= 32'h0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  int tv_pulses = 0;
  always @(negedge clk) if (tohost_valid === 1'b1) tv_pulses++;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_tohost = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at the negedge before the accept edge, so tb_cyc is the
  // pre-increment count the DUT will capture.
  function automatic logic [32:0] model_access(input logic we, input logic [31:0] addr,
                                               input logic [31:0] wdata, input logic [3:0] be);
    logic [31:0] m;
    logic ok;
    m  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    ok = (addr[1:0] == 2'b00) &&
         ((addr < 32'(DEPTH * 4)) || (addr == MMIO) || (addr == MMIO + 32'h4));
    if (!ok) return {1'b1, 32'h0};
    if (we) begin
      if (addr < 32'(DEPTH * 4))
        model_mem[addr[AW+1:2]] = (model_mem[addr[AW+1:2]] & ~m) | (wdata & m);
      else if (addr == MMIO + 32'h4)
        model_tohost = (model_tohost & ~m) | (wdata & m);
      return {1'b0, 32'h0};
    end
    if (addr < 32'(DEPTH * 4)) return {1'b0, model_mem[addr[AW+1:2]]};
    if (addr == MMIO)          return {1'b0, tb_cyc};
    return {1'b0, model_tohost};
  endfunction

  // ---------------- driver ----------------
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold, output logic [31:0] got);
    logic [32:0] e;
    int lat;
    @(negedge clk);
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    exp_q.push_back(model_access(we, addr, wdata, be));
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    // rsp_valid is visible in the (WS+1)th cycle after the accept edge
    check_eq("rsp_latency", 32'(lat), 32'(WS));
    e   = exp_q.pop_front();
    got = rsp_rdata;
    check_eq("rsp_rdata", rsp_rdata, e[31:0]);
    check_eq("rsp_err", 32'(rsp_err), 32'(e[32]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_rdata", rsp_rdata, e[31:0]);
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("rsp_retired", {30'h0, rsp_valid, req_ready}, 32'h1);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd, c1, c2, addr_r;
  int          p0, seen;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'h0);
    check_eq("rst_err", 32'(rsp_err), 32'd0);
    check_eq("rst_tohost", tohost, 32'h0);
    check_eq("rst_tohost_valid", 32'(tohost_valid), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); rst = 1'b0;

    // Full-word store and load-back
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
    check_eq("store_rdata_zero", rd, 32'h0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    check_eq("load_deadbeef", rd, 32'hDEADBEEF);

    // Byte-enable merge, then a held response
    txn(1'b1, 32'h20, 32'hAAAAAAAA, 4'hF, 0, rd);
    txn(1'b1, 32'h20, 32'h11223344, 4'b0101, 0, rd);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 5, rd);
    check_eq("merge_be0101", rd, 32'hAA22AA44);
    txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, rd);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
    check_eq("be0_store_noop", rd, 32'hAA22AA44);

    // TOHOST: pulse per write even with be=0, byte merge
    p0 = tv_pulses;
    txn(1'b1, MMIO + 32'h4, 32'h1, 4'hF, 0, rd);
    check_eq("tohost_val", tohost, 32'h1);
    check_eq("tohost_pulse", 32'(tv_pulses - p0), 32'd1);
    txn(1'b1, MMIO + 32'h4, 32'hFFFF_AB00, 4'b0010, 0, rd);
    txn(1'b1, MMIO + 32'h4, 32'h5555_5555, 4'h0, 0, rd);
    check_eq("tohost_merge", tohost, 32'h0000_AB01);
    check_eq("tohost_pulse3", 32'(tv_pulses - p0), 32'd3);
    txn(1'b0, MMIO + 32'h4, 32'h0, 4'h0, 0, rd);

    // CYCLE: read-only, two loads exactly 10 cycles apart
    txn(1'b1, MMIO, 32'h1234_5678, 4'hF, 0, rd);
    while (tb_cyc < 32'd40) begin @(posedge clk); #1; end
    txn(1'b0, MMIO, 32'h0, 4'h0, 0, c1);
    while (tb_cyc < c1 + 32'd10) begin @(posedge clk); #1; end
    txn(1'b0, MMIO, 32'h0, 4'h0, 1, c2);
    check_eq("cycle_delta", c2 - c1, 32'd10);

    // Faulting accesses leave RAM and tohost untouched
    txn(1'b1, 32'h0, 32'h1357_2468, 4'hF, 0, rd);
    p0 = tv_pulses;
    txn(1'b0, 32'h12, 32'h0, 4'h0, 0, rd);
    txn(1'b0, MMIO + 32'h8, 32'h0, 4'h0, 0, rd);
    txn(1'b0, 32'(DEPTH * 4), 32'h0, 4'h0, 0, rd);
    txn(1'b1, 32'h12, 32'h0BAD_0BAD, 4'hF, 0, rd);
    txn(1'b1, MMIO + 32'h8, 32'h0BAD_0BAD, 4'hF, 0, rd);
    txn(1'b1, MMIO + 32'h6, 32'h0BAD_0BAD, 4'hF, 0, rd);
    txn(1'b1, 32'(DEPTH * 4), 32'h0BAD_0BAD, 4'hF, 0, rd);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 0, rd);
    check_eq("err_no_ram_alias", rd, 32'h1357_2468);
    check_eq("err_tohost_kept", tohost, 32'h0000_AB01);
    check_eq("err_no_pulse", 32'(tv_pulses - p0), 32'd0);

    // Random word traffic over a small window
    for (int k = 0; k < 8; k++)
      txn(1'b1, 32'h100 + 32'(k * 4), $urandom, 4'hF, 0, rd);
    for (int k = 0; k < 12; k++) begin
      addr_r = 32'h100 + 32'($urandom_range(0, 7) * 4);
      txn($urandom_range(0, 1) == 1, addr_r, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 2), rd);
    end

    // Reset while in WAIT: response dropped, committed store kept
    @(negedge clk);
    void'(model_access(1'b1, 32'h30, 32'h0000_5555, 4'hF));
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h0000_5555; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("in_wait", 32'(dbg_state), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("async_rst_ready", 32'(req_ready), 32'd1);
    model_tohost = 32'h0;
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) seen++;
    end
    check_eq("no_dropped_rsp", 32'(seen), 32'd0);
    txn(1'b0, 32'h30, 32'h0, 4'h0, 0, rd);
    check_eq("store_survives_rst", rd, 32'h0000_5555);
    txn(1'b0, MMIO + 32'h4, 32'h0, 4'h0, 0, rd);

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
